// File: rtl/change_dispense_ctrl_if.sv
// Change dispenser bus: payout request from the vending FSM, coin handshake
// to the dispenser, status back to the requester, optional stock controls.
interface change_dispense_if #(
  parameter int AMT_W = 8
);
  logic             change_start;
  logic [AMT_W-1:0] change_amount;
  logic             change_abort;
  logic             coin_ready;
  logic             coin_valid;
  logic [4:0]       coin_sel;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] remaining;
  logic [7:0]       coin_cnt;
  logic             stock_refill;
  logic [4:0]       stock_empty;

  // Requester / dispenser side
  modport master (
    output change_start, change_amount, change_abort, coin_ready, stock_refill,
    input  coin_valid, coin_sel, busy, done, err, remaining, coin_cnt, stock_empty
  );

  // Controller side
  modport slave (
    input  change_start, change_amount, change_abort, coin_ready, stock_refill,
    output coin_valid, coin_sel, busy, done, err, remaining, coin_cnt, stock_empty
  );
endinterface

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: breaks a change amount greedily into 50/20/10/5/1
// coins and issues them one at a time over a valid/ready handshake.
// Optional per-denomination stock tracking: define CHANGE_INVENTORY_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for change_start; stock refill accepted here
// SELECT | pick largest coin <= remaining (and in stock)
// ISSUE  | coin_valid high, coin_sel held until coin_ready
// DONE   | one-cycle done pulse, remaining is 0
// FAULT  | one-cycle err pulse, remaining holds undispensed amount
module change_dispense_ctrl #(
  parameter int AMT_W      = 8,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  change_dispense_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_FAULT
  } state_e;

  state_e           state_q;
  logic [AMT_W-1:0] remaining_q;
  logic [7:0]       coin_cnt_q;
  logic [4:0]       coin_sel_q;
  logic             coin_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [4:0]       stock_ok;
  logic [4:0]       sel_d;
  logic [AMT_W-1:0] remaining_d;
  logic             handshake;

  // Face value of a one-hot coin selection.
  function automatic logic [AMT_W-1:0] coin_value(input logic [4:0] sel);
    logic [AMT_W-1:0] v;
    v = '0;
    case (sel)
      5'b00001: v = AMT_W'(1);
      5'b00010: v = AMT_W'(5);
      5'b00100: v = AMT_W'(10);
      5'b01000: v = AMT_W'(20);
      5'b10000: v = AMT_W'(50);
      default:  v = '0;
    endcase
    return v;
  endfunction

`ifdef CHANGE_INVENTORY_EN
  logic [STOCK_W-1:0] stock_q [5];
  logic [4:0]         stock_empty_w;

  // A denomination is selectable only while its counter is non-zero.
  always_comb begin
    stock_ok      = '0;
    stock_empty_w = '0;
    for (int i = 0; i < 5; i++) begin
      stock_ok[i]      = (stock_q[i] != '0);
      stock_empty_w[i] = (stock_q[i] == '0);
    end
  end

  assign bus.stock_empty = stock_empty_w;
`else
  // Unlimited stock: every denomination is always available.
  assign stock_ok        = '1;
  assign bus.stock_empty = '0;

  logic               unused_stock_refill;
  logic [STOCK_W-1:0] unused_stock_init;
  assign unused_stock_refill = bus.stock_refill;
  assign unused_stock_init   = STOCK_W'(STOCK_INIT);
`endif

  // Greedy pick: largest available coin not exceeding the remaining amount.
  // A zero result means no coin fits, which only happens when stock runs out.
  always_comb begin
    sel_d = '0;
    if (remaining_q >= AMT_W'(50) && stock_ok[4])
      sel_d = 5'b10000;
    else if (remaining_q >= AMT_W'(20) && stock_ok[3])
      sel_d = 5'b01000;
    else if (remaining_q >= AMT_W'(10) && stock_ok[2])
      sel_d = 5'b00100;
    else if (remaining_q >= AMT_W'(5) && stock_ok[1])
      sel_d = 5'b00010;
    else if (remaining_q >= AMT_W'(1) && stock_ok[0])
      sel_d = 5'b00001;
  end

  // Amount left once the coin currently on offer is taken; the selection
  // rule guarantees the coin never exceeds remaining_q.
  always_comb begin
    handshake   = (state_q == S_ISSUE) && bus.coin_ready;
    remaining_d = remaining_q - coin_value(coin_sel_q);
  end

  // Sequencer with registered outputs; handshake is resolved before abort.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      coin_cnt_q   <= '0;
      coin_sel_q   <= '0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef CHANGE_INVENTORY_EN
      for (int i = 0; i < 5; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef CHANGE_INVENTORY_EN
          if (bus.stock_refill)
            for (int i = 0; i < 5; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
`endif
          if (bus.change_start) begin
            remaining_q <= bus.change_amount;
            coin_cnt_q  <= '0;
            if (bus.change_amount == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SELECT;
              busy_q  <= 1'b1;
            end
          end
        end

        S_SELECT: begin
          if (bus.change_abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (sel_d != '0) begin
            coin_sel_q   <= sel_d;
            coin_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end else begin
            state_q <= S_FAULT;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (handshake) begin
            remaining_q  <= remaining_d;
            coin_valid_q <= 1'b0;
            coin_sel_q   <= '0;
            if (coin_cnt_q != 8'hFF) coin_cnt_q <= coin_cnt_q + 8'd1;
`ifdef CHANGE_INVENTORY_EN
            for (int i = 0; i < 5; i++)
              if (coin_sel_q[i]) stock_q[i] <= stock_q[i] - STOCK_W'(1);
`endif
            if (bus.change_abort) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (remaining_d == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SELECT;
            end
          end else if (bus.change_abort) begin
            coin_valid_q <= 1'b0;
            coin_sel_q   <= '0;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
          end
        end

        S_DONE:  state_q <= S_IDLE;
        S_FAULT: state_q <= S_IDLE;
        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          coin_valid_q <= 1'b0;
          coin_sel_q   <= '0;
        end
      endcase
    end
  end

  assign bus.coin_valid = coin_valid_q;
  assign bus.coin_sel   = coin_sel_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.remaining  = remaining_q;
  assign bus.coin_cnt   = coin_cnt_q;

endmodule
